// File: rtl/latch_writer.sv
// Serial gate-pulse writer for a level-sensitive D latch: accepts a word, then sends it LSB first
// as SETUP/STROBE/HOLD frames. Define LATCH_WRITER_PARITY_EN to append an odd-parity frame.
module latch_writer #(
  parameter int WIDTH = 8,
  parameter int SETUP = 1,
  parameter int PULSE = 2,
  parameter int HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             d_out,
  output logic             d_out_n,
  output logic             g_out,
  output logic             busy,
  output logic             done
);

`ifdef LATCH_WRITER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  localparam int MAXPH = (SETUP > PULSE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                         : ((PULSE > HOLD) ? PULSE : HOLD);
  localparam int CW = $clog2(MAXPH) + 1;
  localparam int IW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NBITS-1:0] sh_q;
  logic             d_out_q, g_out_q, done_q, busy_q;
  logic             accept, load, shift, last_bit;
  logic [CW-1:0]    hold_end;

  assign in_ready = (state_q == S_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign last_bit = (idx_q == IW'(NBITS - 1));
  // Outputs lag the state by one register; the final HOLD runs one extra
  // cycle so IDLE (and in_ready) line up with the registered done pulse.
  assign hold_end = last_bit ? CW'(HOLD) : CW'(HOLD - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_q == CW'(SETUP - 1)) begin
          state_d = S_STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == CW'(PULSE - 1)) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == hold_end) begin
          cnt_d = '0;
          if (last_bit) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_SETUP;
            idx_d   = idx_q + IW'(1);
            shift   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      d_out_q <= 1'b0;
      g_out_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      d_out_q <= (state_q == S_SETUP) ? sh_q[0] : d_out_q;
      g_out_q <= (state_q == S_STROBE);
      done_q  <= (state_q == S_HOLD) && (state_d == S_IDLE);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
`ifdef LATCH_WRITER_PARITY_EN
      sh_q <= {~^in_data, in_data};
`else
      sh_q <= in_data;
`endif
    end else if (shift) begin
      sh_q <= sh_q >> 1;
    end
  end

  assign d_out   = d_out_q;
  assign d_out_n = ~d_out_q;
  assign g_out   = g_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_latch_writer.sv
// Directed self-checking bench for latch_writer: default instance (T=4) and a
// SETUP=3/PULSE=1/HOLD=2/WIDTH=4 instance sharing clock and reset.
module tb_latch_writer;

`ifdef LATCH_WRITER_PARITY_EN
  localparam int N1 = 9;
  localparam int N2 = 5;
`else
  localparam int N1 = 8;
  localparam int N2 = 4;
`endif
  localparam int T1 = 4;
  localparam int T2 = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] in_data1 = '0;
  logic       in_valid1 = 1'b0;
  logic       in_ready1, d_out1, d_out_n1, g_out1, busy1, done1;
  logic [3:0] in_data2 = '0;
  logic       in_valid2 = 1'b0;
  logic       in_ready2, d_out2, d_out_n2, g_out2, busy2, done2;

  latch_writer dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .d_out(d_out1), .d_out_n(d_out_n1), .g_out(g_out1), .busy(busy1), .done(done1)
  );

  latch_writer #(.WIDTH(4), .SETUP(3), .PULSE(1), .HOLD(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .d_out(d_out2), .d_out_n(d_out_n2), .g_out(g_out2), .busy(busy2), .done(done2)
  );

  int checks = 0;
  int failures = 0;

  logic [127:0] obs_d, obs_dn, obs_g, obs_done, obs_rdy, obs_busy, mask;
  logic [127:0] exp_d, exp_g, exp_done, exp_rdy, exp_busy;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] bits1(input logic [7:0] v);
`ifdef LATCH_WRITER_PARITY_EN
    return {7'b0, ~^v, v};
`else
    return {8'b0, v};
`endif
  endfunction

  function automatic logic [15:0] bits2(input logic [3:0] v);
`ifdef LATCH_WRITER_PARITY_EN
    return {11'b0, ~^v, v};
`else
    return {12'b0, v};
`endif
  endfunction

  task automatic clear_exp();
    exp_d = '0; exp_g = '0; exp_done = '0; exp_rdy = '0; exp_busy = '0;
  endtask

  // Expected waveform for a word accepted at edge off (sampled #1 after each edge).
  task automatic build_exp(input int off, input int s, input int p, input int h,
                           input int n, input logic [15:0] bits);
    int t;
    int r;
    t = s + p + h;
    exp_g[off] = 1'b0; exp_done[off] = 1'b0; exp_rdy[off] = 1'b0; exp_busy[off] = 1'b1;
    for (int e = off + 1; e < 128; e++) begin
      r = e - off - 1;
      if (r < n * t) begin
        exp_d[e]    = bits[r / t];
        exp_g[e]    = ((r % t) >= s) && ((r % t) < s + p);
        exp_done[e] = 1'b0;
        exp_rdy[e]  = 1'b0;
        exp_busy[e] = 1'b1;
      end else begin
        exp_d[e]    = bits[n - 1];
        exp_g[e]    = 1'b0;
        exp_done[e] = (r == n * t);
        exp_rdy[e]  = 1'b1;
        exp_busy[e] = 1'b0;
      end
    end
  endtask

  task automatic set_mask(input int len);
    mask = '0;
    for (int i = 1; i <= len; i++) mask[i] = 1'b1;
  endtask

  task automatic launch1(input logic [7:0] v);
    @(negedge clk);
    in_data1 = v;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic launch2(input logic [3:0] v);
    @(negedge clk);
    in_data2 = v;
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic capture1(input int len, input int on_at, input int off_at, input logic [7:0] nd);
    obs_d = '0; obs_dn = '0; obs_g = '0; obs_done = '0; obs_rdy = '0; obs_busy = '0;
    set_mask(len);
    for (int e = 1; e <= len; e++) begin
      @(posedge clk);
      #1;
      obs_d[e] = d_out1; obs_dn[e] = d_out_n1; obs_g[e] = g_out1;
      obs_done[e] = done1; obs_rdy[e] = in_ready1; obs_busy[e] = busy1;
      if (e == on_at) begin in_data1 = nd; in_valid1 = 1'b1; end
      if (e == off_at) in_valid1 = 1'b0;
    end
  endtask

  task automatic capture2(input int len);
    obs_d = '0; obs_dn = '0; obs_g = '0; obs_done = '0; obs_rdy = '0; obs_busy = '0;
    set_mask(len);
    for (int e = 1; e <= len; e++) begin
      @(posedge clk);
      #1;
      obs_d[e] = d_out2; obs_dn[e] = d_out_n2; obs_g[e] = g_out2;
      obs_done[e] = done2; obs_rdy[e] = in_ready2; obs_busy[e] = busy2;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (d_out1 !== 1'b0) begin failures++; $display("FAIL reset_d_out: got %b want 0", d_out1); end
    checks++; if (d_out_n1 !== 1'b1) begin failures++; $display("FAIL reset_d_out_n: got %b want 1", d_out_n1); end
    checks++; if (g_out1 !== 1'b0) begin failures++; $display("FAIL reset_g_out: got %b want 0", g_out1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done1); end
    checks++; if (in_ready1 !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready1); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (in_ready1 !== 1'b1) begin failures++; $display("FAIL release_in_ready: got %b want 1", in_ready1); end
    checks++; if (in_ready2 !== 1'b1) begin failures++; $display("FAIL release_in_ready2: got %b want 1", in_ready2); end
  endtask

  task automatic test_single_word();
    int len;
    len = N1 * T1 + 2;
    launch1(8'hA5);
    in_valid1 = 1'b0;
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL single_busy_at_accept: got %b want 1", busy1); end
    clear_exp();
    build_exp(0, 1, 2, 1, N1, bits1(8'hA5));
    capture1(len, -1, -1, 8'h00);
    checks++; if ((obs_d & mask) !== (exp_d & mask)) begin failures++; $display("FAIL single_d_out: got %h want %h", obs_d & mask, exp_d & mask); end
    checks++; if ((obs_dn & mask) !== (~exp_d & mask)) begin failures++; $display("FAIL single_d_out_n: got %h want %h", obs_dn & mask, ~exp_d & mask); end
    checks++; if ((obs_g & mask) !== (exp_g & mask)) begin failures++; $display("FAIL single_g_out: got %h want %h", obs_g & mask, exp_g & mask); end
    checks++; if ((obs_done & mask) !== (exp_done & mask)) begin failures++; $display("FAIL single_done: got %h want %h", obs_done & mask, exp_done & mask); end
    checks++; if ((obs_rdy & mask) !== (exp_rdy & mask)) begin failures++; $display("FAIL single_in_ready: got %h want %h", obs_rdy & mask, exp_rdy & mask); end
    checks++; if (obs_done[N1 * T1 + 1] !== 1'b1) begin failures++; $display("FAIL single_done_edge: got %b want 1 at edge %0d", obs_done[N1 * T1 + 1], N1 * T1 + 1); end
  endtask

  task automatic test_back_to_back();
    int a2;
    int len;
    a2 = N1 * T1 + 2;
    len = a2 + N1 * T1 + 2;
    launch1(8'hFF);
    clear_exp();
    build_exp(0, 1, 2, 1, N1, bits1(8'hFF));
    build_exp(a2, 1, 2, 1, N1, bits1(8'h00));
    capture1(len, 1, a2, 8'h00);
    checks++; if ((obs_d & mask) !== (exp_d & mask)) begin failures++; $display("FAIL b2b_d_out: got %h want %h", obs_d & mask, exp_d & mask); end
    checks++; if ((obs_g & mask) !== (exp_g & mask)) begin failures++; $display("FAIL b2b_g_out: got %h want %h", obs_g & mask, exp_g & mask); end
    checks++; if ((obs_done & mask) !== (exp_done & mask)) begin failures++; $display("FAIL b2b_done: got %h want %h", obs_done & mask, exp_done & mask); end
    checks++; if ((obs_busy & mask) !== (exp_busy & mask)) begin failures++; $display("FAIL b2b_busy: got %h want %h", obs_busy & mask, exp_busy & mask); end
  endtask

  task automatic test_ignore_busy();
    int len;
    len = N1 * T1 + 3;
    launch1(8'hA5);
    in_valid1 = 1'b0;
    clear_exp();
    build_exp(0, 1, 2, 1, N1, bits1(8'hA5));
    capture1(len, 5, N1 * T1 - 1, 8'h3C);
    checks++; if ((obs_d & mask) !== (exp_d & mask)) begin failures++; $display("FAIL ignore_d_out: got %h want %h", obs_d & mask, exp_d & mask); end
    checks++; if ((obs_busy & mask) !== (exp_busy & mask)) begin failures++; $display("FAIL ignore_busy: got %h want %h", obs_busy & mask, exp_busy & mask); end
    checks++; if ((obs_done & mask) !== (exp_done & mask)) begin failures++; $display("FAIL ignore_done: got %h want %h", obs_done & mask, exp_done & mask); end
  endtask

  task automatic test_reset_mid_word();
    bit found;
    bit seen_done;
    found = 1'b0;
    seen_done = 1'b0;
    launch1(8'hA5);
    in_valid1 = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (g_out1 === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL midrst_wait_gate: got no gate pulse want one within 20 cycles"); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (g_out1 !== 1'b0) begin failures++; $display("FAIL midrst_g_out_async: got %b want 0", g_out1); end
    checks++; if (d_out1 !== 1'b0) begin failures++; $display("FAIL midrst_d_out: got %b want 0", d_out1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy1); end
    checks++; if (in_ready1 !== 1'b0) begin failures++; $display("FAIL midrst_in_ready: got %b want 0", in_ready1); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done1 !== 1'b0) seen_done = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N1 * T1 + 2; i++) begin
      @(posedge clk);
      #1;
      if (done1 !== 1'b0) seen_done = 1'b1;
    end
    checks++; if (seen_done) begin failures++; $display("FAIL midrst_no_done: got done pulse want none"); end
    launch1(8'h3C);
    in_valid1 = 1'b0;
    clear_exp();
    build_exp(0, 1, 2, 1, N1, bits1(8'h3C));
    capture1(N1 * T1 + 2, -1, -1, 8'h00);
    checks++; if ((obs_d & mask) !== (exp_d & mask)) begin failures++; $display("FAIL midrst_next_d_out: got %h want %h", obs_d & mask, exp_d & mask); end
    checks++; if ((obs_g & mask) !== (exp_g & mask)) begin failures++; $display("FAIL midrst_next_g_out: got %h want %h", obs_g & mask, exp_g & mask); end
    checks++; if ((obs_done & mask) !== (exp_done & mask)) begin failures++; $display("FAIL midrst_next_done: got %h want %h", obs_done & mask, exp_done & mask); end
  endtask

  task automatic test_param_sweep();
    launch2(4'b0110);
    in_valid2 = 1'b0;
    clear_exp();
    build_exp(0, 3, 1, 2, N2, bits2(4'b0110));
    capture2(N2 * T2 + 2);
    checks++; if ((obs_d & mask) !== (exp_d & mask)) begin failures++; $display("FAIL sweep_d_out: got %h want %h", obs_d & mask, exp_d & mask); end
    checks++; if ((obs_g & mask) !== (exp_g & mask)) begin failures++; $display("FAIL sweep_g_out: got %h want %h", obs_g & mask, exp_g & mask); end
    checks++; if ((obs_done & mask) !== (exp_done & mask)) begin failures++; $display("FAIL sweep_done: got %h want %h", obs_done & mask, exp_done & mask); end
    checks++; if ((obs_rdy & mask) !== (exp_rdy & mask)) begin failures++; $display("FAIL sweep_in_ready: got %h want %h", obs_rdy & mask, exp_rdy & mask); end
    checks++; if (obs_done[N2 * T2 + 1] !== 1'b1) begin failures++; $display("FAIL sweep_done_edge: got %b want 1 at edge %0d", obs_done[N2 * T2 + 1], N2 * T2 + 1); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_word();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/latch_writer.md
# latch_writer

Serial writer for the level-sensitive D-latch cell (data `d`, enable `clk`, complementary outputs). It accepts a parallel word through a valid/ready handshake. It then presents the word one bit at a time on a data line and wraps each bit in a gate pulse that has programmable setup, pulse-width and hold margins. It is the driving end of the latch interface and is used to exercise the latch and latch-based storage in lab benches.

## Interface
- `WIDTH`, 8: bits per word; ≥1.
- `SETUP`, 1: cycles data is stable before the gate rises; ≥1.
- `PULSE`, 2: cycles the gate is held high; ≥1.
- `HOLD`, 1: cycles data is stable after the gate falls; ≥1.

- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_data` in WIDTH: word to send; sampled on accept.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: block can accept a word.
- `d_out` out 1: serial data, drives latch `d`.
- `d_out_n` out 1: always `~d_out`.
- `g_out` out 1: gate pulse, drives latch `clk`.
- `busy` out 1: word in progress.
- `done` out 1: one-cycle pulse when a word completes.

## Operation
- Reset values: state IDLE, `d_out`=0, `d_out_n`=1, `g_out`=0, `busy`=0, `done`=0, `in_ready`=0.
- `in_ready` = (state==IDLE) && !rst.
- Accept occurs on a rising edge with `in_valid && in_ready`. On accept:
  - `in_data` loads into the shift register.
  - The bit index clears.
  - The FSM enters SETUP.
- Bits are sent LSB first.
- FSM states: IDLE, SETUP, STROBE, HOLD (plus PARITY_EN behaviour, see Configuration).
  - IDLE → SETUP on accept.
  - SETUP: `d_out` = current bit, `g_out`=0, for SETUP cycles → STROBE.
  - STROBE: `g_out`=1, `d_out` unchanged, for PULSE cycles → HOLD.
  - HOLD: `g_out`=0, `d_out` unchanged, for HOLD cycles. Then:
    - last bit → IDLE with `done`=1 for one cycle;
    - otherwise shift and → SETUP for the next bit.
- `d_out` changes only on entry to SETUP. It never changes while `g_out`=1 or during HOLD.
- In IDLE, `d_out` retains the last bit sent.
- `busy` = (state != IDLE).
- Phase counter width is clog2(max(SETUP,PULSE,HOLD))+1. Bit index width is clog2(WIDTH+1). Neither counter may wrap within a phase.
- `in_valid` and `in_data` are ignored while busy. No queueing.
- Back-to-back words: `in_ready` is high in the same cycle as `done`, so a word can be accepted on the next edge with no dead cycle.
- Reset mid-word: all outputs return to their reset values immediately. `g_out` drops asynchronously, and the word is discarded with no `done`.

## Timing
- Per-bit period T = SETUP+PULSE+HOLD cycles.
- With the accept at edge 0:
  - bit k is on `d_out` from edge 1+k·T;
  - `g_out` is high from edge 1+k·T+SETUP for PULSE cycles.
- `done` is asserted in the cycle starting at edge 1+N·T, where N = WIDTH (or WIDTH+1 with parity). `in_ready` is high in that same cycle.
- All outputs are registered except `in_ready` and `d_out_n`. `d_out_n` is the inverse of the registered `d_out`.

## Configuration
- `LATCH_WRITER_PARITY_EN`:
  - Defined: after the WIDTH data bits, one extra bit frame sends odd parity, ~^`in_data` as captured, with the same SETUP/STROBE/HOLD timing. N = WIDTH+1.
  - Undefined: no parity frame. N = WIDTH.

## Test plan
- Reset: assert `rst` for 3 cycles → `d_out`=0, `d_out_n`=1, `g_out`=0, `busy`=0, `in_ready`=0. Release `rst` → `in_ready`=1 next cycle.
- Single word, defaults (T=4), `in_data`=8'hA5:
  - `d_out` sequence 1,0,1,0,0,1,0,1;
  - 8 `g_out` pulses, each 2 cycles wide, rising 1 cycle after each `d_out` change;
  - `done` at edge 33 after accept (edge 37 with parity, parity bit 1).
- Back-to-back: 8'hFF then 8'h00, with `in_valid` held high → second accept on the edge after `done`; no idle gap; `d_out` falls to 0 only at the second word's first SETUP.
- Ignore while busy: change `in_data` to 8'h3C mid-word → serialized bits remain those of the original word; no second accept until `done`.
- Reset mid-word: assert `rst` while `g_out`=1 → `g_out`=0 immediately (same cycle, asynchronous); no `done`; next word after release is sent correctly.
- Parameter sweep: SETUP=3, PULSE=1, HOLD=2, WIDTH=4, data 4'b0110 → T=6; `g_out` high 1 cycle starting 3 cycles after each bit change; `done` at edge 25 after accept.
